uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 123 ++++++++++++
 tb/tb_uart_rx_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver: 2-flop synchronizer, edge-triggered start, mid-bit sampling.
module uart_rx_core #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int BIT_CNT = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 2;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   logic sync1;
   logic sync2;
   logic line_prev;
   logic [2:0] fill;
   logic fall;

   // The reset value of the synchronizer is 1; fill blocks the fake edge a
   // line that is already low at reset release would otherwise produce.
   assign fall = fill[2] & line_prev & ~sync2;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         line_prev <= 1'b1;
         fill      <= 3'b000;
      end else begin
         sync1     <= rx_in;
         sync2     <= sync1;
         line_prev <= sync2;
         fill      <= {fill[1:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         data_out  <= 8'h00;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= 3'd0;
               if (fall) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= sync2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {sync2, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (sync2) begin
                     data_out <= shreg;
                     rx_done  <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed and random frames against a byte-level receive model.
module tb_uart_rx_core;

   localparam int B    = 16;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [7:0] data_out;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int vectors    = 0;
   int miscompares = 0;

   int         cyc = 0;
   int         run = 0;
   int         both_cnt = 0;
   logic [8:0] ev_q[$];
   int         ev_cyc[$];
   int         busy_runs[$];

   uart_rx_core #(.CLK_FREQ(1600), .BAUD(100)) dut (
      .clk(clk),
      .rst(rst),
      .rx_in(rx_in),
      .data_out(data_out),
      .rx_done(rx_done),
      .frame_err(frame_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_done || frame_err) begin
         ev_q.push_back({frame_err, data_out});
         ev_cyc.push_back(cyc);
      end
      if (rx_done && frame_err) both_cnt <= both_cnt + 1;
      if (busy) begin
         run <= run + 1;
      end else begin
         if (run > 0) busy_runs.push_back(run);
         run <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      hold(1'b0, B);
      for (int i = 0; i < 8; i++) hold(b[i], B);
      hold(stop, B);
   endtask

   initial begin
      int         base;
      int         rb;
      int         t0;
      int         d;
      logic [7:0] rb_byte;
      logic       rb_stop;
      logic [7:0] last_good;
      logic [8:0] exp_q[$];
      logic [7:0] b;

      rst   = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data_out", data_out, 8'h00);
      check("reset_rx_done", rx_done, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst = 1'b0;
      hold(1'b1, 4);

      // Single good frame, with start-to-pulse latency window
      base = ev_q.size();
      t0 = cyc + 1;
      send_frame(8'h55, 1'b1);
      hold(1'b1, B);
      check("f55_count", ev_q.size() - base, 1);
      check("f55_event", ev_q[base], {1'b0, 8'h55});
      d = ev_cyc[base] - t0;
      check("f55_latency_window", (d >= HALF + 9*B - 2) && (d <= HALF + 9*B + 2), 1);
      check("f55_busy_after", busy, 1'b0);

      // Back-to-back frames with no idle gap
      base = ev_q.size();
      send_frame(8'hA3, 1'b1);
      send_frame(8'h00, 1'b1);
      hold(1'b1, B);
      check("b2b_count", ev_q.size() - base, 2);
      check("b2b_first", ev_q[base], {1'b0, 8'hA3});
      check("b2b_second", ev_q[base+1], {1'b0, 8'h00});
      check("b2b_data_out", data_out, 8'h00);

      // Short glitch must be rejected in START
      base = ev_q.size();
      rb = busy_runs.size();
      hold(1'b0, 3);
      hold(1'b1, 2*B);
      check("glitch_events", ev_q.size() - base, 0);
      check("glitch_busy_runs", busy_runs.size() - rb, 1);
      check("glitch_busy_len_ok", (busy_runs[rb] >= 1) && (busy_runs[rb] <= HALF + 3), 1);

      // Framing error keeps the previous byte; a following break starts nothing
      base = ev_q.size();
      send_frame(8'h5A, 1'b1);
      send_frame(8'hFF, 1'b0);
      hold(1'b0, 3*B);
      check("ferr_count", ev_q.size() - base, 2);
      check("ferr_first", ev_q[base], {1'b0, 8'h5A});
      check("ferr_second", ev_q[base+1], {1'b1, 8'h5A});
      check("ferr_data_out", data_out, 8'h5A);
      check("break_busy", busy, 1'b0);
      hold(1'b1, B);

      // Reset in the middle of bit 4 of 0x3C
      base = ev_q.size();
      b = 8'h3C;
      hold(1'b0, B);
      for (int i = 0; i < 4; i++) hold(b[i], B);
      hold(b[4], B/2);
      rst = 1'b1;
      #1;
      check("midrst_data_out", data_out, 8'h00);
      check("midrst_rx_done", rx_done, 1'b0);
      check("midrst_frame_err", frame_err, 1'b0);
      check("midrst_busy", busy, 1'b0);
      rx_in = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold(1'b1, 4);
      check("midrst_no_pulse", ev_q.size() - base, 0);
      send_frame(8'hC3, 1'b1);
      hold(1'b1, B);
      check("after_rst_count", ev_q.size() - base, 1);
      check("after_rst_event", ev_q[base], {1'b0, 8'hC3});

      // Line held low across reset release
      rx_in = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = ev_q.size();
      rb = busy_runs.size();
      hold(1'b0, 20*B);
      check("lowrel_busy", busy, 1'b0);
      check("lowrel_busy_runs", busy_runs.size() - rb, 0);
      check("lowrel_events", ev_q.size() - base, 0);
      hold(1'b1, 2*B);
      send_frame(8'h81, 1'b1);
      hold(1'b1, B);
      check("f81_count", ev_q.size() - base, 1);
      check("f81_event", ev_q[base], {1'b0, 8'h81});
      check("f81_data_out", data_out, 8'h81);

      // Random frames: each good frame yields its byte, each bad stop keeps the last good byte
      last_good = 8'h81;
      base = ev_q.size();
      for (int k = 0; k < 24; k++) begin
         rb_byte = 8'($urandom);
         rb_stop = ($urandom_range(0, 3) != 0);
         send_frame(rb_byte, rb_stop);
         if (rb_stop) begin
            last_good = rb_byte;
            exp_q.push_back({1'b0, rb_byte});
            hold(1'b1, $urandom_range(0, B));
         end else begin
            exp_q.push_back({1'b1, last_good});
            hold(1'b1, B + $urandom_range(0, B));
         end
      end
      hold(1'b1, B);
      check("rand_count", ev_q.size() - base, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
         if (base + k < ev_q.size()) check("rand_event", ev_q[base+k], exp_q[k]);
         else check("rand_event_missing", 0, 1);
      end
      check("rand_data_out", data_out, last_good);
      check("never_both_pulses", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
